// File: rtl/nubus_pkg.sv
// Shared NuBus types and constants: FSM states, TM ACK status codes,
// response status codes and TM size codes.
package nubus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARB   = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_RESP  = 3'd4
  } nubus_state_t;

  // {tm1_n, tm0_n} as sampled during the slave ACK cycle
  localparam logic [1:0] TM_ACK_OK      = 2'b11;
  localparam logic [1:0] TM_ACK_ERROR   = 2'b10;
  localparam logic [1:0] TM_ACK_TIMEOUT = 2'b01;
  localparam logic [1:0] TM_ACK_RETRY   = 2'b00;

  localparam logic [1:0] RSP_OK        = 2'b00;
  localparam logic [1:0] RSP_ERROR     = 2'b01;
  localparam logic [1:0] RSP_TIMEOUT   = 2'b10;
  localparam logic [1:0] RSP_RETRY_EXH = 2'b11;

  localparam logic [1:0] TM_SIZE_BYTE  = 2'b00;
  localparam logic [1:0] TM_SIZE_HALF  = 2'b01;
  localparam logic [1:0] TM_SIZE_BLOCK = 2'b10;
  localparam logic [1:0] TM_SIZE_WORD  = 2'b11;

  // A try-again-later ACK only reaches this mapping once retries are exhausted.
  function automatic logic [1:0] ack_to_status(input logic [1:0] tm);
    case (tm)
      TM_ACK_OK:      return RSP_OK;
      TM_ACK_ERROR:   return RSP_ERROR;
      TM_ACK_TIMEOUT: return RSP_TIMEOUT;
      default:        return RSP_RETRY_EXH;
    endcase
  endfunction

endpackage

// File: rtl/nubus_bus_monitor.sv
// Tracks whether another card owns the bus: busy from a foreign START
// until the next ACK. Shared between master and slave paths.
module nubus_bus_monitor (
  input  logic clk,
  input  logic srst,
  input  logic start_n,
  input  logic ack_n,
  input  logic own_start,
  output logic bus_busy
);

  logic busy_reg;
  logic foreign_start;

  assign foreign_start = !start_n && !own_start;

  always_ff @(posedge clk) begin
    if (srst) begin
      busy_reg <= 1'b0;
    end else if (foreign_start) begin
      busy_reg <= 1'b1;
    end else if (!ack_n) begin
      busy_reg <= 1'b0;
    end
  end

  // A START seen this very cycle already blocks our own START.
  assign bus_busy = busy_reg || foreign_start;

endmodule

// File: rtl/nubus_master_seq.sv
// NuBus master transaction sequencer: arbitration, START/DATA phases, ACK
// handling with retry. Optional DATA-phase abort via NUBUS_MASTER_TIMEOUT_EN.
module nubus_master_seq
  import nubus_pkg::*;
#(
  parameter int MAX_RETRY      = 4,
  parameter int ARB_MIN_CYCLES = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        nubus_clk,
  input  logic        nubus_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_status,
  output logic        rqst_n_3v3,
  output logic        rqst_oe_n,
  output logic        arbcy_n,
  input  logic        grant,
  output logic        nubus_master_dir,
  output logic        start_n_3v3,
  input  logic        start_n_in,
  input  logic        ack_n_in,
  output logic        tm0_n_out,
  output logic        tm1_n_out,
  input  logic        tm0_n_in,
  input  logic        tm1_n_in,
  output logic [31:0] ad_n_out,
  output logic        ad_oe,
  input  logic [31:0] ad_n_in
);

  localparam logic [7:0] ARB_MIN   = 8'(ARB_MIN_CYCLES);
  localparam logic [7:0] RETRY_MAX = 8'(MAX_RETRY);

  nubus_state_t state_reg, state_next;
  logic [7:0]   arb_cnt_reg, arb_cnt_inc;
  logic [7:0]   retry_cnt_reg;
  logic         write_reg, size0_reg;
  logic [31:0]  addr_reg, wdata_reg, rdata_reg;
  logic [1:0]   status_reg;
  logic         bus_busy, own_start;
  logic [1:0]   ack_tm;
  logic         ack_seen, retry_again, tmo_hit;
  logic         unused_size_msb;

  assign unused_size_msb = req_size[1];
  assign own_start       = (state_reg == ST_START);
  assign ack_tm          = {tm1_n_in, tm0_n_in};
  assign ack_seen        = !ack_n_in;
  assign retry_again     = (ack_tm == TM_ACK_RETRY) && (retry_cnt_reg < RETRY_MAX);

  nubus_bus_monitor u_bus_monitor (
    .clk       (nubus_clk),
    .srst      (nubus_rst),
    .start_n   (start_n_in),
    .ack_n     (ack_n_in),
    .own_start (own_start),
    .bus_busy  (bus_busy)
  );

  // Grant run length including the current cycle, saturating at the threshold.
  always_comb begin
    arb_cnt_inc = 8'd0;
    if (grant) begin
      arb_cnt_inc = (arb_cnt_reg >= ARB_MIN) ? arb_cnt_reg : arb_cnt_reg + 8'd1;
    end
  end

`ifdef NUBUS_MASTER_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt_reg;

  // Counts cycles since START, so the abort lands exactly TIMEOUT_CYCLES later.
  always_ff @(posedge nubus_clk) begin
    if (nubus_rst) begin
      tmo_cnt_reg <= 16'd0;
    end else if (state_reg == ST_START) begin
      tmo_cnt_reg <= 16'd1;
    end else if (state_reg == ST_DATA) begin
      tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
    end else begin
      tmo_cnt_reg <= 16'd0;
    end
  end

  assign tmo_hit = (tmo_cnt_reg >= TMO_LAST);
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge nubus_clk) begin
    if (nubus_rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (req_valid) state_next = ST_ARB;
      ST_ARB:   if ((arb_cnt_inc >= ARB_MIN) && !bus_busy) state_next = ST_START;
      ST_START: state_next = ST_DATA;
      ST_DATA: begin
        if (ack_seen) begin
          state_next = retry_again ? ST_ARB : ST_RESP;
        end else if (tmo_hit) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge nubus_clk) begin
    if (nubus_rst) begin
      arb_cnt_reg   <= 8'd0;
      retry_cnt_reg <= 8'd0;
      write_reg     <= 1'b0;
      size0_reg     <= 1'b0;
      addr_reg      <= 32'd0;
      wdata_reg     <= 32'd0;
      rdata_reg     <= 32'd0;
      status_reg    <= RSP_OK;
    end else begin
      arb_cnt_reg <= (state_reg == ST_ARB) ? arb_cnt_inc : 8'd0;
      if (state_reg == ST_IDLE && req_valid) begin
        write_reg <= req_write;
        size0_reg <= req_size[0];
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata;
      end
      if (state_reg == ST_DATA && ack_seen) begin
        if (retry_again) begin
          retry_cnt_reg <= retry_cnt_reg + 8'd1;
        end else begin
          status_reg <= ack_to_status(ack_tm);
          rdata_reg  <= (ack_tm == TM_ACK_OK && !write_reg) ? ~ad_n_in : 32'd0;
        end
      end else if (state_reg == ST_DATA && tmo_hit) begin
        status_reg <= RSP_TIMEOUT;
        rdata_reg  <= 32'd0;
      end
      if (state_reg == ST_RESP) begin
        retry_cnt_reg <= 8'd0;
      end
    end
  end

  always_comb begin
    req_ready        = 1'b0;
    rsp_valid        = 1'b0;
    rqst_n_3v3       = 1'b1;
    rqst_oe_n        = 1'b1;
    arbcy_n          = 1'b1;
    start_n_3v3      = 1'b1;
    tm1_n_out        = 1'b1;
    tm0_n_out        = 1'b1;
    nubus_master_dir = 1'b0;
    ad_oe            = 1'b0;
    ad_n_out         = '1;
    case (state_reg)
      ST_IDLE: req_ready = req_valid;
      ST_ARB: begin
        rqst_n_3v3 = 1'b0;
        rqst_oe_n  = 1'b0;
        arbcy_n    = 1'b0;
      end
      ST_START: begin
        start_n_3v3      = 1'b0;
        nubus_master_dir = 1'b1;
        ad_oe            = 1'b1;
        ad_n_out         = ~addr_reg;
        tm1_n_out        = ~write_reg;
        tm0_n_out        = ~size0_reg;
      end
      ST_DATA: begin
        nubus_master_dir = 1'b1;
        if (write_reg) begin
          ad_oe    = 1'b1;
          ad_n_out = ~wdata_reg;
        end
      end
      ST_RESP: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign rsp_rdata  = rdata_reg;
  assign rsp_status = status_reg;

endmodule

// File: tb/tb_nubus_master_seq.sv
// Directed bench for nubus_master_seq: vector table plus hand-written
// arbitration, retry, no-ACK and reset sequences. Honours NUBUS_MASTER_TIMEOUT_EN.
module tb_nubus_master_seq;
  import nubus_pkg::*;

  logic        nubus_clk = 1'b0;
  logic        nubus_rst = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        grant = 1'b0, foreign_start_n = 1'b1;
  logic        ack_n_in = 1'b1, tm0_n_in = 1'b1, tm1_n_in = 1'b1;
  logic [31:0] ad_n_in = '1;
  logic        start_n_in;
  logic        req_ready, rsp_valid, rqst_n_3v3, rqst_oe_n, arbcy_n;
  logic        nubus_master_dir, start_n_3v3, tm0_n_out, tm1_n_out, ad_oe;
  logic [31:0] rsp_rdata, ad_n_out;
  logic [1:0]  rsp_status;

  int n_tests = 0;
  int n_fail  = 0;

  assign start_n_in = start_n_3v3 & foreign_start_n;

  always #5 nubus_clk = ~nubus_clk;

  nubus_master_seq dut (
    .nubus_clk(nubus_clk), .nubus_rst(nubus_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
    .rqst_n_3v3(rqst_n_3v3), .rqst_oe_n(rqst_oe_n), .arbcy_n(arbcy_n),
    .grant(grant), .nubus_master_dir(nubus_master_dir),
    .start_n_3v3(start_n_3v3), .start_n_in(start_n_in), .ack_n_in(ack_n_in),
    .tm0_n_out(tm0_n_out), .tm1_n_out(tm1_n_out),
    .tm0_n_in(tm0_n_in), .tm1_n_in(tm1_n_in),
    .ad_n_out(ad_n_out), .ad_oe(ad_oe), .ad_n_in(ad_n_in)
  );

  typedef struct {
    string       name;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic [1:0]  ack_tm;
    logic [31:0] slave_ad_n;
    logic [31:0] exp_ad_start;
    logic [31:0] exp_ad_data;
    logic [1:0]  exp_tm_n;
    logic [1:0]  exp_status;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge nubus_clk);
    #1;
  endtask

  function automatic logic [9:0] ctl_vec();
    return {rqst_n_3v3, rqst_oe_n, arbcy_n, start_n_3v3, tm1_n_out, tm0_n_out,
            nubus_master_dir, ad_oe, req_ready, rsp_valid};
  endfunction

  // Presents a one-cycle read request; returns in the first ARB cycle.
  task automatic issue_read(input logic [31:0] addr, input logic g);
    req_valid = 1'b1; req_write = 1'b0; req_addr = addr;
    req_size = TM_SIZE_WORD; grant = g;
    #2;
    check("req_ready", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_start(input int max_cyc, output int k);
    k = 0;
    while (start_n_3v3 !== 1'b0 && k < max_cyc) begin
      tick();
      k++;
    end
  endtask

  // Called in the START cycle: slave ACKs in the following DATA cycle.
  task automatic ack_only(input logic [1:0] tm, input logic [31:0] adn);
    tick();
    ack_n_in = 1'b0; {tm1_n_in, tm0_n_in} = tm; ad_n_in = adn;
    tick();
    ack_n_in = 1'b1; {tm1_n_in, tm0_n_in} = 2'b11; ad_n_in = '1;
    #2;
  endtask

  task automatic finish_ack(input string name, input logic [1:0] tm, input logic [31:0] adn,
                            input logic [1:0] exp_st, input logic [31:0] exp_rd);
    ack_only(tm, adn);
    check({name, "_rsp_valid"}, rsp_valid, 1'b1);
    check({name, "_status"}, rsp_status, exp_st);
    check({name, "_rdata"}, rsp_rdata, exp_rd);
    $display("[TB] txn %s: status=%b rdata=0x%h", name, rsp_status, rsp_rdata);
    tick();
    #2;
    check({name, "_rsp_one_cycle"}, rsp_valid, 1'b0);
  endtask

  task automatic run_vec(input vec_t v);
    int k;
    req_valid = 1'b1; req_write = v.write; req_addr = v.addr;
    req_wdata = v.wdata; req_size = v.size; grant = 1'b1;
    #2;
    check({v.name, "_req_ready"}, req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    wait_start(20, k);
    check({v.name, "_start_cycle"}, k + 1, 3);
    check({v.name, "_start_ad"}, ad_n_out, v.exp_ad_start);
    check({v.name, "_start_tm"}, {tm1_n_out, tm0_n_out}, v.exp_tm_n);
    check({v.name, "_start_ctl"}, {ad_oe, nubus_master_dir, rqst_n_3v3, arbcy_n}, 4'b1111);
    tick();
    ack_n_in = 1'b0; {tm1_n_in, tm0_n_in} = v.ack_tm; ad_n_in = v.slave_ad_n;
    #2;
    check({v.name, "_data_oe"}, {nubus_master_dir, ad_oe}, {1'b1, v.write});
    if (v.write) check({v.name, "_data_ad"}, ad_n_out, v.exp_ad_data);
    tick();
    ack_n_in = 1'b1; {tm1_n_in, tm0_n_in} = 2'b11; ad_n_in = '1;
    #2;
    check({v.name, "_rsp_valid"}, rsp_valid, 1'b1);
    check({v.name, "_status"}, rsp_status, v.exp_status);
    check({v.name, "_rdata"}, rsp_rdata, v.exp_rdata);
    check({v.name, "_resp_dir"}, {nubus_master_dir, ad_oe}, 2'b00);
    $display("[TB] txn %s: status=%b rdata=0x%h", v.name, rsp_status, rsp_rdata);
    tick();
    #2;
    check({v.name, "_rsp_one_cycle"}, rsp_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, cnt, viol;
    //          name     wr    addr          wdata         size           ack    slave_ad_n    ad@START      ad@DATA       tm_n   status         rdata
    vecs[0] = '{"rd_ok",  1'b0, 32'h0000_1000, 32'h0,        TM_SIZE_WORD,  2'b11, 32'h2152_4110, 32'hFFFF_EFFF, 32'hFFFF_FFFF, 2'b10, RSP_OK,    32'hDEAD_BEEF};
    vecs[1] = '{"wr_ok",  1'b1, 32'hF900_0010, 32'h1234_5678, TM_SIZE_BLOCK, 2'b11, 32'hFFFF_FFFF, 32'h06FF_FFEF, 32'hEDCB_A987, 2'b01, RSP_OK,    32'h0};
    vecs[2] = '{"rd_err", 1'b0, 32'h0000_0004, 32'h0,        TM_SIZE_HALF,  2'b10, 32'hAA55_AA55, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 2'b10, RSP_ERROR, 32'h0};
    vecs[3] = '{"rd_tmo", 1'b0, 32'h8000_0000, 32'h0,        TM_SIZE_BYTE,  2'b01, 32'h0000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 2'b11, RSP_TIMEOUT, 32'h0};
    vecs[4] = '{"wr_err", 1'b1, 32'h0000_FFFC, 32'hA5A5_A5A5, TM_SIZE_WORD,  2'b10, 32'hFFFF_FFFF, 32'hFFFF_0003, 32'h5A5A_5A5A, 2'b00, RSP_ERROR, 32'h0};

    repeat (3) tick();
    nubus_rst = 1'b0;
    #2;
    check("reset_ctl", ctl_vec(), 10'b11_1111_0000);
    check("reset_ad", ad_n_out, 32'hFFFF_FFFF);
    check("reset_rsp", {30'd0, rsp_status}, 32'd0);
    check("reset_rdata", rsp_rdata, 32'd0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Grant 1,0,1,1 across ARB cycles 1..4: START only in cycle 5.
    issue_read(32'h0000_2000, 1'b0);
    grant = 1'b1;
    #2;
    check("arb_ctl", {rqst_n_3v3, rqst_oe_n, arbcy_n}, 3'b000);
    tick(); grant = 1'b0;
    tick(); grant = 1'b1;
    tick();
    #2;
    check("toggle_no_early_start", start_n_3v3, 1'b1);
    tick();
    check("toggle_start", start_n_3v3, 1'b0);
    finish_ack("toggle", 2'b11, 32'hF452_0FF2, RSP_OK, 32'h0BAD_F00D);

    // Foreign START in the cycle our grant count reaches the threshold.
    issue_read(32'h0000_3000, 1'b1);
    tick(); foreign_start_n = 1'b0;
    tick(); foreign_start_n = 1'b1;
    #2;
    check("busy_wins", start_n_3v3, 1'b1);
    tick(); ack_n_in = 1'b0;
    #2;
    check("busy_hold", start_n_3v3, 1'b1);
    tick(); ack_n_in = 1'b1;
    #2;
    check("busy_clear_lag", start_n_3v3, 1'b1);
    tick();
    check("start_after_ack", start_n_3v3, 1'b0);
    finish_ack("foreign", 2'b11, 32'h8765_4320, RSP_OK, 32'h789A_BCDF);

    // Five try-again-later ACKs: four re-arbitrations, then retries exhausted.
    issue_read(32'h0000_0100, 1'b1);
    for (int r = 0; r < 5; r++) begin
      wait_start(10, k);
      check("retry_start_cycle", k, 2);
      ack_only(2'b00, 32'h0);
      if (r < 4) begin
        check("retry_rearb", {arbcy_n, rsp_valid}, 2'b00);
      end else begin
        check("retry_rsp_valid", rsp_valid, 1'b1);
        check("retry_status", rsp_status, RSP_RETRY_EXH);
        check("retry_rdata", rsp_rdata, 32'd0);
        $display("[TB] txn retry_exh: status=%b rdata=0x%h", rsp_status, rsp_rdata);
      end
    end
    tick();

    // No ACK at all after START.
    issue_read(32'h0000_0200, 1'b1);
    wait_start(10, k);
`ifdef NUBUS_MASTER_TIMEOUT_EN
    cnt = 0;
    while (rsp_valid !== 1'b1 && cnt < 400) begin
      tick();
      cnt++;
    end
    check("abort_cycles", cnt, 255);
    check("abort_status", rsp_status, RSP_TIMEOUT);
    check("abort_release", {nubus_master_dir, ad_oe}, 2'b00);
    $display("[TB] txn abort: status=%b after %0d cycles", rsp_status, cnt);
    tick();
    issue_read(32'h0000_0300, 1'b1);
    wait_start(10, k);
    tick();
`else
    viol = 0;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (rsp_valid !== 1'b0 || nubus_master_dir !== 1'b1) viol++;
    end
    check("data_waits", viol, 0);
    $display("[TB] txn no_ack: still waiting after 300 cycles");
`endif

    // Reset while in DATA.
    nubus_rst = 1'b1;
    tick();
    nubus_rst = 1'b0;
    #2;
    check("mid_reset_ctl", ctl_vec(), 10'b11_1111_0000);
    check("mid_reset_ad", ad_n_out, 32'hFFFF_FFFF);
    check("mid_reset_rsp", {rsp_rdata[29:0], rsp_status}, 32'd0);
    viol = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (start_n_3v3 !== 1'b1 || rsp_valid !== 1'b0) viol++;
    end
    check("no_restart", viol, 0);
    $display("[TB] txn mid_reset: idle after reset");

    // Retry count must have cleared: one TAL then success.
    issue_read(32'h0000_0400, 1'b1);
    wait_start(10, k);
    ack_only(2'b00, 32'h0);
    check("post_reset_rearb", {arbcy_n, rsp_valid}, 2'b00);
    wait_start(10, k);
    check("post_reset_start", start_n_3v3, 1'b0);
    finish_ack("post_reset", 2'b11, 32'hEDCB_A987, RSP_OK, 32'h1234_5678);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
